mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
Control-path stage for the repeated-addition multiplier datapath. Accepts two operands over a valid/ready operand port and drives them onto the datapath's shared data bus. Sequences the load/clear/add/decrement strobes, monitors eqz and signals completion. Optionally swaps the operands so the smaller one goes into the down-counter, which minimises the number of iterations.

Parameters:
WIDTH, 16, operand/bus width; must match the datapath bus width
SWAP_EN, 1, 1 = load min(a,b) into counter B; 0 = first beat to A and second beat to B unconditionally

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
op_data  in  WIDTH  operand beat (beat0 = a, beat1 = b)
op_valid  in  1  op_data valid
op_ready  out  1  block can accept a beat
data_out  out  WIDTH  bus driven to datapath data input
LdA  out  1  load datapath register A from bus
LdB  out  1  load datapath counter B from bus
LdP  out  1  load product register P with A+P
clrP  out  1  clear product register P
decB  out  1  decrement counter B
eqz  in  1  datapath flag: counter B == 0 (combinational from B)
busy  out  1  operation in progress (states LOAD_A..RUN)
done  out  1  single-cycle completion pulse; product P is valid from this cycle
iter_count  out  WIDTH  number of add iterations of the current/last operation

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - op_ready=1 after reset.
  - LdA/LdB/LdP/clrP/decB/done/busy = 0; data_out = 0; iter_count = 0; operand buffers = 0.
  - The datapath has no reset. Its stale contents are irrelevant because every operation reloads A and B and clears P.
- Handshake: a beat transfers on a rising edge with op_valid & op_ready. op_ready=1 only in IDLE and WAIT_B. op_data is sampled only on transfer.
- States:
  - IDLE: op_ready=1. On transfer, store a_reg ← op_data and go to WAIT_B.
  - WAIT_B: op_ready=1. On transfer, store b_reg ← op_data and go to LOAD_A. Stays in WAIT_B indefinitely if op_valid is low.
  - LOAD_A: LdA=1; data_out = mcand; go to LOAD_B.
  - LOAD_B: LdB=1, clrP=1; data_out = mplier; iter_count ← 0; go to RUN.
  - RUN: if eqz=0, assert LdP=1 and decB=1, increment iter_count, and stay in RUN. If eqz=1, deassert all strobes and go to DONE.
  - DONE: done=1 for exactly one cycle; go to IDLE.
- Operand selection:
  - SWAP_EN=1: mplier = min(a_reg,b_reg) and mcand = max(a_reg,b_reg), compared unsigned. On a tie, a_reg is the mcand.
  - SWAP_EN=0: mcand = a_reg, mplier = b_reg.
- data_out = 0 in every state other than LOAD_A and LOAD_B.
- Timing: let the beat1 transfer cycle be cycle 0 and n = mplier.
  - Cycle 1: LOAD_A.
  - Cycle 2: LOAD_B.
  - Cycles 3..3+n: RUN (n add cycles plus one exit cycle).
  - Cycle 4+n: done=1.
  - op_ready=1 again in cycle 5+n.
- Outputs are registered or decoded from state only, with no combinational path from op_valid to any strobe. op_ready depends on state only.
- iter_count holds its final value (== n) after done, until the next LOAD_B. It wraps modulo 2^WIDTH, which is unreachable because n ≤ 2^WIDTH−1.
- Product arithmetic is performed by the datapath, modulo 2^WIDTH; this block does not flag overflow.
- Zero operand: mplier=0 gives eqz=1 on first RUN cycle, so zero iterations, done in cycle 4, and P=0.
- Strobes are never asserted together except the pairs (LdB, clrP) and (LdP, decB).
- Reset asserted mid-operation aborts immediately: no done pulse, partial beats discarded, next operation starts from beat0.
- busy=1 in LOAD_A, LOAD_B and RUN; busy=0 in IDLE, WAIT_B and DONE.

Test Plan:
- SWAP_EN=1, beats a=5, b=3 → LOAD_A data_out=5; LOAD_B data_out=3; 3 cycles with LdP&decB; done in cycle 7; iter_count=3; datapath P=15.
- SWAP_EN=1, a=3, b=5 → same mcand/mplier (5/3), done in cycle 7, P=15. With SWAP_EN=0: mplier=5, done in cycle 9, iter_count=5, P=15.
- a=1234, b=0 → zero LdP cycles; done in cycle 4; iter_count=0; P=0. Also a=0, b=0 → P=0, done in cycle 4.
- a=16'hFFFF, b=2 → 2 iterations; P=16'hFFFE (wrapped); done in cycle 6.
- op_valid held high continuously with 4 operations queued → op_ready low from LOAD_A through DONE; each operation's done pulse is exactly 1 cycle; no beat lost or duplicated.
- rst_n pulsed low in RUN (a=100, b=50, iteration 20) → all strobes 0 and busy 0 immediately; no done pulse; next pair a=2, b=3 gives P=6 with clrP asserted in LOAD_B.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: control path for the repeated-addition multiplier datapath.
//
// Takes two operand beats over a valid/ready port, drives the multiplicand
// and then the multiplier onto the shared datapath bus, and runs the
// add/decrement loop until the datapath reports that counter B is zero.
// With SWAP_EN=1 the smaller operand goes into the down-counter so the loop
// runs as few times as possible.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op_data/op_valid    operand beat in (beat0 = a, beat1 = b)
//   op_ready            block can accept a beat (IDLE, WAIT_B only)
//   data_out            bus to the datapath data input
//   LdA, LdB, LdP       load strobes for A, counter B, and product P (P <= A+P)
//   clrP, decB          clear P, decrement counter B
//   eqz                 datapath flag: counter B == 0
//   busy                operation in progress (LOAD_A..RUN)
//   done                one-cycle completion pulse, P valid in this cycle
//   iter_count          add iterations of the current/last operation
module mul_seq_ctrl #(
    parameter int WIDTH   = 16,
    parameter bit SWAP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op_data,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             LdA,
    output logic             LdB,
    output logic             LdP,
    output logic             clrP,
    output logic             decB,
    input  logic             eqz,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] iter_count
);

    typedef enum logic [2:0] {
        IDLE, WAIT_B, LOAD_A, LOAD_B, RUN, DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg, b_reg;

    // Multiplicand selection: larger operand when swapping (a wins a tie).
    function automatic logic [WIDTH-1:0] pick_mcand(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        if (SWAP_EN) return (a >= b) ? a : b;
        return a;
    endfunction

    function automatic logic [WIDTH-1:0] pick_mplier(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        if (SWAP_EN) return (a >= b) ? b : a;
        return b;
    endfunction

    // The add strobes must follow eqz in the same cycle so the loop stops
    // exactly when B reaches zero; they depend only on state and eqz.
    assign LdP  = (state == RUN) && !eqz;
    assign decB = (state == RUN) && !eqz;

    // All other outputs are registered: each transition sets the outputs
    // that belong to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            iter_count <= '0;
            data_out   <= '0;
            op_ready   <= 1'b1;
            LdA        <= 1'b0;
            LdB        <= 1'b0;
            clrP       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            LdA      <= 1'b0;
            LdB      <= 1'b0;
            clrP     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        a_reg <= op_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (op_valid) begin
                        b_reg    <= op_data;
                        state    <= LOAD_A;
                        op_ready <= 1'b0;
                        busy     <= 1'b1;
                        LdA      <= 1'b1;
                        // b_reg is not updated yet, so select from the beat itself
                        data_out <= pick_mcand(a_reg, op_data);
                    end
                end
                LOAD_A: begin
                    state    <= LOAD_B;
                    LdB      <= 1'b1;
                    clrP     <= 1'b1;
                    data_out <= pick_mplier(a_reg, b_reg);
                end
                LOAD_B: begin
                    state      <= RUN;
                    iter_count <= '0;
                end
                RUN: begin
                    if (eqz) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        iter_count <= iter_count + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: one instance with operand swapping (index 1) and
// one without (index 0), each driving a behavioural model of the
// repeated-addition datapath so the resulting product can be checked.
module tb_mul_seq_ctrl;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][W-1:0] op_data, dout, iter;
    logic [1:0]        op_valid, rdy, lda, ldb, ldp, clrp, decb, eqz, busy, done;

    mul_seq_ctrl #(.WIDTH(W), .SWAP_EN(1'b0)) u_noswap (
        .clk(clk), .rst_n(rst_n), .op_data(op_data[0]), .op_valid(op_valid[0]),
        .op_ready(rdy[0]), .data_out(dout[0]), .LdA(lda[0]), .LdB(ldb[0]),
        .LdP(ldp[0]), .clrP(clrp[0]), .decB(decb[0]), .eqz(eqz[0]),
        .busy(busy[0]), .done(done[0]), .iter_count(iter[0]));

    mul_seq_ctrl #(.WIDTH(W), .SWAP_EN(1'b1)) u_swap (
        .clk(clk), .rst_n(rst_n), .op_data(op_data[1]), .op_valid(op_valid[1]),
        .op_ready(rdy[1]), .data_out(dout[1]), .LdA(lda[1]), .LdB(ldb[1]),
        .LdP(ldp[1]), .clrP(clrp[1]), .decB(decb[1]), .eqz(eqz[1]),
        .busy(busy[1]), .done(done[1]), .iter_count(iter[1]));

    // Datapath model: no reset, like the real datapath.
    logic [1:0][W-1:0] A, B, P;
    always_ff @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (lda[d]) A[d] <= dout[d];
            if (ldb[d]) B[d] <= dout[d];
            else if (decb[d]) B[d] <= B[d] - 1'b1;
            if (clrp[d]) P[d] <= '0;
            else if (ldp[d]) P[d] <= P[d] + A[d];
        end
    end
    always_comb begin
        eqz = '0;
        for (int d = 0; d < 2; d++) eqz[d] = (B[d] == '0);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic [W-1:0] mc1, mp1;  // swapping instance
        int           dn1, dn0;  // done cycle, swap / no-swap
        logic [W-1:0] p;
    } vec_t;

    vec_t vecs[7];

    // Per-instance results of the last collected operation.
    logic [W-1:0] r_mc[2], r_mp[2], r_p[2];
    int           r_dn[2], r_ldp[2], r_dcnt[2];
    logic         r_clr[2], r_rdy[2];

    task automatic send_beats(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op_valid   = 2'b11;
        op_data[0] = a;
        op_data[1] = a;
        @(posedge clk);
        #1;
        op_data[0] = b;
        op_data[1] = b;
        @(posedge clk);  // beat1 transfer: cycle 0
        #1;
        op_valid = 2'b00;
    endtask

    task automatic collect();
        int last;
        for (int d = 0; d < 2; d++) begin
            r_mc[d] = 'x; r_mp[d] = 'x; r_p[d] = 'x;
            r_dn[d] = -1; r_ldp[d] = 0; r_dcnt[d] = 0;
            r_clr[d] = 1'b0; r_rdy[d] = 1'b0;
        end
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (lda[d]) r_mc[d] = dout[d];
                if (ldb[d]) begin
                    r_mp[d]  = dout[d];
                    r_clr[d] = clrp[d];
                end
                if (ldp[d]) r_ldp[d]++;
                if (done[d]) begin
                    r_dcnt[d]++;
                    if (r_dn[d] < 0) begin
                        r_dn[d] = k;
                        r_p[d]  = P[d];
                    end
                end
                if (r_dn[d] >= 0 && k == r_dn[d] + 1) r_rdy[d] = rdy[d];
            end
            if (r_dn[0] >= 0 && r_dn[1] >= 0) begin
                last = (r_dn[0] > r_dn[1]) ? r_dn[0] : r_dn[1];
                if (k >= last + 1) break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        send_beats(a, b);
        collect();
    endtask

    // Streaming test: four operations on the swapping instance with op_valid high.
    logic [W-1:0] beats[8];
    logic [W-1:0] sprod[4];
    int           n_done;
    bit           drv_fin;

    initial begin
        op_valid = 2'b00;
        op_data  = '0;

        vecs[0] = '{a:16'd5,    b:16'd3,    mc1:16'd5,    mp1:16'd3, dn1:7,  dn0:7,  p:16'd15};
        vecs[1] = '{a:16'd3,    b:16'd5,    mc1:16'd5,    mp1:16'd3, dn1:7,  dn0:9,  p:16'd15};
        vecs[2] = '{a:16'd1234, b:16'd0,    mc1:16'd1234, mp1:16'd0, dn1:4,  dn0:4,  p:16'd0};
        vecs[3] = '{a:16'd0,    b:16'd0,    mc1:16'd0,    mp1:16'd0, dn1:4,  dn0:4,  p:16'd0};
        vecs[4] = '{a:16'hFFFF, b:16'd2,    mc1:16'hFFFF, mp1:16'd2, dn1:6,  dn0:6,  p:16'hFFFE};
        vecs[5] = '{a:16'd7,    b:16'd7,    mc1:16'd7,    mp1:16'd7, dn1:11, dn0:11, p:16'd49};
        vecs[6] = '{a:16'd0,    b:16'd9,    mc1:16'd9,    mp1:16'd0, dn1:4,  dn0:13, p:16'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst op_ready", {31'd0, rdy[1]}, 32'd1);
        chk("rst strobes", {25'd0, lda[1], ldb[1], ldp[1], clrp[1], decb[1], busy[1], done[1]}, 32'd0);
        chk("rst data_out", {16'd0, dout[1]}, 32'd0);
        chk("rst iter_count", {16'd0, iter[1]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven operations on both instances
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b);
            for (int d = 0; d < 2; d++) begin
                logic [W-1:0] emc, emp;
                int           edn;
                emc = d ? vecs[i].mc1 : vecs[i].a;
                emp = d ? vecs[i].mp1 : vecs[i].b;
                edn = d ? vecs[i].dn1 : vecs[i].dn0;
                chk($sformatf("v%0d.%0d LOAD_A bus", i, d), {16'd0, r_mc[d]}, {16'd0, emc});
                chk($sformatf("v%0d.%0d LOAD_B bus", i, d), {16'd0, r_mp[d]}, {16'd0, emp});
                chk($sformatf("v%0d.%0d done cycle", i, d), r_dn[d], edn);
                chk($sformatf("v%0d.%0d add cycles", i, d), r_ldp[d], {16'd0, emp});
                chk($sformatf("v%0d.%0d done pulses", i, d), r_dcnt[d], 32'd1);
                chk($sformatf("v%0d.%0d iter_count", i, d), {16'd0, iter[d]}, {16'd0, emp});
                chk($sformatf("v%0d.%0d product", i, d), {16'd0, r_p[d]}, {16'd0, vecs[i].p});
                chk($sformatf("v%0d.%0d ready after done", i, d), {31'd0, r_rdy[d]}, 32'd1);
            end
        end

        // Back-to-back operations with op_valid held high (swapping instance)
        beats = '{16'd2, 16'd3, 16'd4, 16'd1, 16'd0, 16'd5, 16'd6, 16'd6};
        sprod = '{16'd6, 16'd4, 16'd0, 16'd36};
        n_done  = 0;
        drv_fin = 1'b0;
        fork
            begin
                int  idx;
                bit  r;
                idx = 0;
                for (int c = 0; c < 300 && idx < 8; c++) begin
                    @(negedge clk);
                    op_valid[1] = 1'b1;
                    op_data[1]  = beats[idx];
                    r = rdy[1];
                    @(posedge clk);
                    if (r) idx++;
                end
                @(negedge clk);
                op_valid[1] = 1'b0;
                drv_fin = 1'b1;
            end
            begin
                bit prev_done;
                prev_done = 1'b0;
                for (int c = 0; c < 400 && n_done < 4; c++) begin
                    @(negedge clk);
                    if (busy[1] || done[1])
                        chk($sformatf("stream ready low c%0d", c), {31'd0, rdy[1]}, 32'd0);
                    if (done[1] && prev_done)
                        chk("stream done width", 32'd2, 32'd1);
                    if (done[1]) begin
                        chk($sformatf("stream product %0d", n_done), {16'd0, P[1]}, {16'd0, sprod[n_done]});
                        n_done++;
                    end
                    prev_done = done[1];
                end
            end
        join
        chk("stream done count", n_done, 32'd4);
        chk("stream driver finished", {31'd0, drv_fin}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("stream no extra done", {31'd0, done[1]}, 32'd0);

        // Reset in the middle of RUN
        send_beats(16'd100, 16'd50);
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (iter[1] == 16'd20) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("reached iteration 20", {31'd0, hit}, 32'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort strobes", {27'd0, lda[1], ldb[1], ldp[1], clrp[1], decb[1]}, 32'd0);
        chk("abort busy/done", {30'd0, busy[1], done[1]}, 32'd0);
        chk("abort op_ready", {31'd0, rdy[1]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int nd;
            nd = 0;
            repeat (6) begin
                @(negedge clk);
                if (done[1]) nd++;
            end
            chk("abort no done pulse", nd, 32'd0);
        end
        run_op(16'd2, 16'd3);
        chk("post-abort mcand", {16'd0, r_mc[1]}, 32'd3);
        chk("post-abort mplier", {16'd0, r_mp[1]}, 32'd2);
        chk("post-abort clrP in LOAD_B", {31'd0, r_clr[1]}, 32'd1);
        chk("post-abort product", {16'd0, r_p[1]}, 32'd6);
        chk("post-abort done cycle", r_dn[1], 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
